// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the instruction-cycle controller.
package cpu_ctrl_pkg;

    // Phase values produced by the external 2-bit phase counter.
    typedef enum logic [1:0] {
        PH_FETCH     = 2'd0,
        PH_DECODE    = 2'd1,
        PH_EXECUTE   = 2'd2,
        PH_WRITEBACK = 2'd3
    } phase_e;

    // Controller operating state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ctrl_state_e;

    // Top nibble of the instruction that halts the core.
    localparam logic [3:0] HLT_OPCODE_DEFAULT = 4'hF;

endpackage

// File: rtl/cycle_controller_if.sv
// Bundle of phase-counter, memory and datapath-strobe signals around the controller.
interface cycle_controller_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       phase;
    logic             start;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic             cnt_clr;
    logic             mem_req;
    logic [WIDTH-1:0] ir;
    logic             pc_inc;
    logic             alu_en;
    logic             reg_we;
    logic             busy;
    logic             halted;

    // Controller side: consumes phase/start/memory, drives strobes.
    modport master (
        input  phase, start, mem_ack, mem_rdata,
        output cnt_clr, mem_req, ir, pc_inc, alu_en, reg_we, busy, halted
    );

    // Environment side: phase counter, memory and datapath.
    modport slave (
        output phase, start, mem_ack, mem_rdata,
        input  cnt_clr, mem_req, ir, pc_inc, alu_en, reg_we, busy, halted
    );
endinterface

// File: rtl/cycle_controller_phase_decoder.sv
// 2-to-4 one-hot decode of the phase counter value.
module phase_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] phase_i,
    output logic [3:0] onehot_o
);

    // Combinational one-hot decode; bit n is set in phase n.
    always_comb begin
        onehot_o = 4'b0000;
        case (phase_e'(phase_i))
            PH_FETCH:     onehot_o = 4'b0001;
            PH_DECODE:    onehot_o = 4'b0010;
            PH_EXECUTE:   onehot_o = 4'b0100;
            PH_WRITEBACK: onehot_o = 4'b1000;
            default:      onehot_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/cycle_controller.sv
// Instruction-cycle controller: turns the phase counter value into datapath
// strobes, holds the counter at FETCH while idle, halted or waiting on memory.
module cycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter logic [3:0] HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic              clk,
    input  logic              clr_n,
    cycle_controller_if.master bus
);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [3:0]       ph_s;
    logic             cnt_clr_s, mem_req_s, pc_inc_s, alu_en_s, reg_we_s;
    logic             busy_s, halted_s;

    phase_decoder u_phase_decoder (
        .phase_i  (bus.phase),
        .onehot_o (ph_s)
    );

    // Next state, instruction capture and strobe decode.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_clr_s = 1'b0;
        mem_req_s = 1'b0;
        pc_inc_s  = 1'b0;
        alu_en_s  = 1'b0;
        reg_we_s  = 1'b0;
        busy_s    = 1'b0;
        halted_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s = 1'b1;
                if (ph_s[0]) begin
                    mem_req_s = 1'b1;
                    if (bus.mem_ack) begin
                        ir_d     = bus.mem_rdata;
                        pc_inc_s = 1'b1;
                    end else begin
                        // Hold the counter at FETCH and retry next cycle.
                        cnt_clr_s = 1'b1;
                    end
                end else if (ph_s[1]) begin
                    if (ir_q[WIDTH-1 -: 4] == HLT_OPCODE) begin
                        cnt_clr_s = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (ph_s[2]) begin
                    alu_en_s = 1'b1;
                end else if (ph_s[3]) begin
                    // Stores/branches (MSB set) never write the register file.
                    reg_we_s = ~ir_q[WIDTH-1];
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                cnt_clr_s = 1'b1;
                halted_s  = 1'b1;
                if (bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and instruction register with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.cnt_clr = cnt_clr_s;
    assign bus.mem_req = mem_req_s;
    assign bus.ir      = ir_q;
    assign bus.pc_inc  = pc_inc_s;
    assign bus.alu_en  = alu_en_s;
    assign bus.reg_we  = reg_we_s;
    assign bus.busy    = busy_s;
    assign bus.halted  = halted_s;

endmodule

// File: tb/tb_cycle_controller.sv
// Self-checking bench for cycle_controller with an external phase counter
// and a cycle-level behavioural model of the instruction cycle.
module tb_cycle_controller;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    // Model: 0 idle, 1 run, 2 halt; phase 0..3; instruction register.
    int         m_mode  = 0;
    int         m_phase = 0;
    logic [7:0] m_ir    = 8'h00;

    always #5 clk = ~clk;

    cycle_controller_if #(.WIDTH(8)) bus();

    cycle_controller #(.WIDTH(8), .HLT_OPCODE(4'hF)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    // External 2-bit phase counter with synchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus.phase <= 2'd0;
        end else if (bus.cnt_clr) begin
            bus.phase <= 2'd0;
        end else begin
            bus.phase <= bus.phase + 2'd1;
        end
    end

    // {cnt_clr, mem_req, pc_inc, alu_en, reg_we, busy, halted, ir, phase}
    function automatic logic [16:0] obs_vec();
        return {bus.cnt_clr, bus.mem_req, bus.pc_inc, bus.alu_en, bus.reg_we,
                bus.busy, bus.halted, bus.ir, bus.phase};
    endfunction

    function automatic logic [16:0] exp_vec();
        logic run, hlt, clr;
        run = (m_mode == 1);
        hlt = (m_ir[7:4] == 4'hF);
        clr = !run || (m_phase == 0 && !bus.mem_ack) || (m_phase == 1 && hlt);
        return {clr, run && m_phase == 0, run && m_phase == 0 && bus.mem_ack,
                run && m_phase == 2, run && m_phase == 3 && m_ir < 8'h80,
                run, m_mode == 2, m_ir, 2'(m_phase)};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_ir    = 8'h00;
    endtask

    task automatic drive(input logic s, input logic a, input logic [7:0] d);
        bus.start     = s;
        bus.mem_ack   = a;
        bus.mem_rdata = d;
        #3;
    endtask

    // Step the model from the current inputs and move past the next edge.
    task automatic advance();
        logic [16:0] e;
        int          nm, np;
        logic [7:0]  nir;
        e   = exp_vec();
        nm  = m_mode;
        nir = m_ir;
        if (m_mode == 1 && m_phase == 0 && bus.mem_ack) nir = bus.mem_rdata;
        if (m_mode != 1 && bus.start) nm = 1;
        else if (m_mode == 1 && m_phase == 1 && m_ir[7:4] == 4'hF) nm = 2;
        np = e[16] ? 0 : (m_phase + 1) % 4;
        @(posedge clk);
        if (clr_n) begin
            m_mode  = nm;
            m_phase = np;
            m_ir    = nir;
        end
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        model_reset();
        drive(1'b0, 1'b1, 8'h12);
        checks++;
        if (obs_vec() !== 17'h10000) begin
            failures++;
            $display("FAIL reset_vals obs=%h exp=%h", obs_vec(), 17'h10000);
        end
        advance();
        clr_n = 1'b1;
        drive(1'b0, 1'b1, 8'h12);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle obs=%h exp=%h", obs_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_basic();
        int pc_cnt = 0;
        drive(1'b1, 1'b1, 8'h12);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL basic_start obs=%h exp=%h", obs_vec(), exp_vec());
        end
        advance();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 8'h12);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL basic_cyc%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (bus.mem_req !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_memreq obs=%b exp=1", bus.mem_req);
                end
            end
            if (i == 1) begin
                checks++;
                if (bus.ir !== 8'h12) begin
                    failures++;
                    $display("FAIL basic_ir obs=%h exp=12", bus.ir);
                end
            end
            if (bus.pc_inc === 1'b1) pc_cnt++;
            advance();
        end
        checks++;
        if (pc_cnt != 3) begin
            failures++;
            $display("FAIL basic_pcinc obs=%0d exp=3", pc_cnt);
        end
    endtask

    task automatic test_wait();
        int total = 0;
        for (int k = 0; k < 8 && m_phase != 0; k++) begin
            drive(1'b0, 1'b1, 8'h12);
            advance();
        end
        for (int w = 0; w < 3; w++) begin
            drive(1'b0, 1'b0, 8'hAA);
            checks++;
            if (obs_vec() !== exp_vec() || bus.phase !== 2'd0 ||
                bus.mem_req !== 1'b1 || bus.pc_inc !== 1'b0) begin
                failures++;
                $display("FAIL wait_cyc%0d obs=%h exp=%h", w, obs_vec(), exp_vec());
            end
            advance();
            total++;
        end
        drive(1'b0, 1'b1, 8'h34);
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc_inc !== 1'b1) begin
            failures++;
            $display("FAIL wait_ack obs=%h exp=%h", obs_vec(), exp_vec());
        end
        advance();
        total++;
        for (int k = 0; k < 8 && bus.phase !== 2'd0; k++) begin
            drive(1'b0, 1'b1, 8'h34);
            checks++;
            if (obs_vec() !== exp_vec() || bus.ir !== 8'h34) begin
                failures++;
                $display("FAIL wait_body obs=%h exp=%h", obs_vec(), exp_vec());
            end
            advance();
            total++;
        end
        checks++;
        if (total != 7) begin
            failures++;
            $display("FAIL wait_len obs=%0d exp=7", total);
        end
    endtask

    task automatic test_msb();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h85);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL msb_cyc%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i == 2) begin
                checks++;
                if (bus.alu_en !== 1'b1) begin
                    failures++;
                    $display("FAIL msb_alu obs=%b exp=1", bus.alu_en);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.reg_we !== 1'b0) begin
                    failures++;
                    $display("FAIL msb_we obs=%b exp=0", bus.reg_we);
                end
            end
            advance();
        end
    endtask

    task automatic test_halt();
        drive(1'b0, 1'b1, 8'hF0);
        advance();
        drive(1'b0, 1'b1, 8'hF0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.cnt_clr !== 1'b1) begin
            failures++;
            $display("FAIL halt_decode obs=%h exp=%h", obs_vec(), exp_vec());
        end
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            checks++;
            if (obs_vec() !== exp_vec() || bus.halted !== 1'b1 || bus.phase !== 2'd0 ||
                bus.alu_en !== 1'b0 || bus.reg_we !== 1'b0 || bus.ir !== 8'hF0) begin
                failures++;
                $display("FAIL halt_hold%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            advance();
        end
        drive(1'b1, 1'b1, 8'h21);
        advance();
        drive(1'b0, 1'b1, 8'h21);
        checks++;
        if (obs_vec() !== exp_vec() || bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL halt_restart obs=%h exp=%h", obs_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8 && m_phase != 2; k++) begin
            drive(1'b0, 1'b1, 8'h21);
            advance();
        end
        drive(1'b0, 1'b1, 8'h21);
        clr_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== 17'h10000 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rstmid_now obs=%h exp=%h", obs_vec(), 17'h10000);
        end
        advance();
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h21);
            checks++;
            if (obs_vec() !== exp_vec() || bus.mem_req !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_idle%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            advance();
        end
        drive(1'b1, 1'b1, 8'h21);
        advance();
        drive(1'b0, 1'b1, 8'h21);
        checks++;
        if (obs_vec() !== exp_vec() || bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_start obs=%h exp=%h", obs_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_ignore();
        for (int k = 0; k < 8 && m_phase != 0; k++) begin
            drive(1'b0, 1'b1, 8'h56);
            advance();
        end
        for (int i = 0; i < 12; i++) begin
            if (m_phase == 0) drive(1'(i % 2), 1'b1, 8'h56);
            else drive(1'(i % 2), 1'($urandom_range(0, 1)), 8'($urandom));
            checks++;
            if (obs_vec() !== exp_vec() || bus.busy !== 1'b1 ||
                bus.phase !== 2'(i % 4) || (i >= 1 && bus.ir !== 8'h56)) begin
                failures++;
                $display("FAIL ignore_cyc%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0), 8'($urandom));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cyc%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        test_reset();
        test_basic();
        test_wait();
        test_msb();
        test_halt();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
